// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for the 5-stage PPU: shadows rd/RF_LE/L for EX, MEM and WB and
// resolves operand forwarding, load-use stalls, branch flushes and memory-wait freezes.
module pipeline_hazard_ctrl #(
  parameter int unsigned RA_W         = 5,
  parameter int unsigned LU_STALL_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_rf_le,
  input  logic            id_load,
  input  logic            ex_br_taken,
  input  logic            mem_wait,
  output logic            pc_le,
  output logic            ifid_le,
  output logic            ifid_flush,
  output logic            idex_nop,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            stalled
);

  typedef enum logic [1:0] {StRun, StLuStall, StFlush} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            ex_v_q, ex_le_q, ex_ld_q;
  logic [RA_W-1:0] ex_rd_q;
  logic            mem_v_q, mem_le_q;
  logic [RA_W-1:0] mem_rd_q;
  logic            wb_v_q, wb_le_q;
  logic [RA_W-1:0] wb_rd_q;

  logic            hit_ex_a, hit_mem_a, hit_wb_a;
  logic            hit_ex_b, hit_mem_b, hit_wb_b;
  logic            load_use;
  logic [1:0]      sel_a, sel_b;

  function automatic logic slot_hit(logic use_rs, logic [RA_W-1:0] rs, logic v, logic le,
                                    logic [RA_W-1:0] rd);
    return use_rs && v && le && (rd == rs) && (rs != '0);
  endfunction

  always_comb begin
    hit_ex_a  = slot_hit(id_use_rs1, id_rs1, ex_v_q, ex_le_q, ex_rd_q);
    hit_mem_a = slot_hit(id_use_rs1, id_rs1, mem_v_q, mem_le_q, mem_rd_q);
    hit_wb_a  = slot_hit(id_use_rs1, id_rs1, wb_v_q, wb_le_q, wb_rd_q);
    hit_ex_b  = slot_hit(id_use_rs2, id_rs2, ex_v_q, ex_le_q, ex_rd_q);
    hit_mem_b = slot_hit(id_use_rs2, id_rs2, mem_v_q, mem_le_q, mem_rd_q);
    hit_wb_b  = slot_hit(id_use_rs2, id_rs2, wb_v_q, wb_le_q, wb_rd_q);
    load_use  = ex_ld_q && (hit_ex_a || hit_ex_b);

    // A load's data is not available in EX; fall through to older producers.
    if (hit_ex_a && !ex_ld_q) sel_a = 2'b01;
    else if (hit_mem_a)       sel_a = 2'b10;
    else if (hit_wb_a)        sel_a = 2'b11;
    else                      sel_a = 2'b00;

    if (hit_ex_b && !ex_ld_q) sel_b = 2'b01;
    else if (hit_mem_b)       sel_b = 2'b10;
    else if (hit_wb_b)        sel_b = 2'b11;
    else                      sel_b = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_wait) begin
      unique case (state_q)
        StRun, StFlush: begin
          if (ex_br_taken) begin
            state_d = StFlush;
          end else if (load_use && (LU_STALL_CYC > 1)) begin
            state_d = StLuStall;
            cnt_d   = 2'(LU_STALL_CYC - 1);
          end else begin
            state_d = StRun;
          end
        end
        StLuStall: begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    pc_le      = 1'b1;
    ifid_le    = 1'b1;
    ifid_flush = 1'b0;
    idex_nop   = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    if (rst_n) begin
      fwd_a = sel_a;
      fwd_b = sel_b;
      if (mem_wait) begin
        pc_le   = 1'b0;
        ifid_le = 1'b0;
      end else begin
        unique case (state_q)
          StRun, StFlush: begin
            if (ex_br_taken) begin
              ifid_flush = 1'b1;
              idex_nop   = 1'b1;
            end else if (load_use) begin
              pc_le    = 1'b0;
              ifid_le  = 1'b0;
              idex_nop = 1'b1;
            end
          end
          StLuStall: begin
            pc_le    = 1'b0;
            ifid_le  = 1'b0;
            idex_nop = 1'b1;
          end
          default: ;
        endcase
      end
    end
    stalled = !pc_le;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q   <= 1'b0;
      ex_le_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      ex_rd_q  <= '0;
      mem_v_q  <= 1'b0;
      mem_le_q <= 1'b0;
      mem_rd_q <= '0;
      wb_v_q   <= 1'b0;
      wb_le_q  <= 1'b0;
      wb_rd_q  <= '0;
    end else if (!mem_wait) begin
      wb_v_q   <= mem_v_q;
      wb_le_q  <= mem_le_q;
      wb_rd_q  <= mem_rd_q;
      mem_v_q  <= ex_v_q;
      mem_le_q <= ex_le_q;
      mem_rd_q <= ex_rd_q;
      ex_v_q   <= !idex_nop;
      ex_le_q  <= id_rf_le;
      ex_ld_q  <= id_load;
      ex_rd_q  <= id_rd;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl against an in-flight instruction
// list model (EX/MEM/WB as a 3-deep history of issued instructions).
module tb_pipeline_hazard_ctrl;
  localparam int unsigned RA_W = 5;
  localparam int unsigned LU   = 2;
  localparam int          NCYC = 3000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [RA_W-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic            id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_rf_le = 1'b0, id_load = 1'b0;
  logic            ex_br_taken = 1'b0, mem_wait = 1'b0;
  logic            pc_le, ifid_le, ifid_flush, idex_nop, stalled;
  logic [1:0]      fwd_a, fwd_b;

  pipeline_hazard_ctrl #(.RA_W(RA_W), .LU_STALL_CYC(LU)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_rf_le   (id_rf_le),
    .id_load    (id_load),
    .ex_br_taken(ex_br_taken),
    .mem_wait   (mem_wait),
    .pc_le      (pc_le),
    .ifid_le    (ifid_le),
    .ifid_flush (ifid_flush),
    .idex_nop   (idex_nop),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stalled    (stalled)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            le;
    logic            ld;
  } slot_t;

  // ctrl = {pc_le, ifid_le, ifid_flush, idex_nop, stalled}
  typedef struct {
    logic [4:0] ctrl;
    logic [3:0] fwd;
  } exp_t;

  slot_t hist[3];  // index = distance ahead of ID minus one (0 = EX)
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    bubbles = 0;

  function automatic logic [1:0] ref_fwd(logic use_rs, logic [RA_W-1:0] rs);
    if (!use_rs || rs == 0) return 2'b00;
    for (int d = 0; d < 3; d++) begin
      if (hist[d].v && hist[d].le && hist[d].rd == rs && !(d == 0 && hist[d].ld))
        return 2'(d + 1);
    end
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({pc_le, ifid_le, ifid_flush, idex_nop, stalled} !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl t=%0t got {pc,ifid,flush,nop,stall}=%b want %b", $time,
                 {pc_le, ifid_le, ifid_flush, idex_nop, stalled}, e.ctrl);
      end
      checks++;
      if ({fwd_a, fwd_b} !== e.fwd) begin
        errors++;
        $display("FAIL fwd t=%0t got a=%b b=%b want a=%b b=%b", $time, fwd_a, fwd_b,
                 e.fwd[3:2], e.fwd[1:0]);
      end
    end
  end

  initial begin
    logic            p_rst = 1'b0, p_mw = 1'b0, p_nop = 1'b0, p_le = 1'b0, p_ld = 1'b0;
    logic [RA_W-1:0] p_rd = '0;
    logic            hold = 1'b0;
    int              p_bub_next = 0;
    int              mw_left = 0;
    int              nres = 0;
    logic            lu;
    exp_t            e;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      // Retire the previous cycle into the model.
      if (!p_rst) begin
        for (int d = 0; d < 3; d++) hist[d] = '{1'b0, '0, 1'b0, 1'b0};
        bubbles = 0;
      end else if (!p_mw) begin
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '{!p_nop, p_rd, p_le, p_ld};
        bubbles = p_bub_next;
      end
      #1;
      // Drive this cycle.
      if (c < 3) rst_n = 1'b0;
      else if (bubbles > 0 && nres < 4 && $urandom_range(0, 2) == 0) begin
        rst_n = 1'b0;
        nres++;
      end else rst_n = 1'b1;

      if (mw_left > 0) begin
        mem_wait = 1'b1;
        mw_left--;
      end else if ($urandom_range(0, 11) == 0) begin
        mem_wait = 1'b1;
        mw_left  = $urandom_range(0, 2);
      end else mem_wait = 1'b0;

      if (!hold) begin
        id_rs1     = RA_W'($urandom_range(0, 7));
        id_rs2     = RA_W'($urandom_range(0, 7));
        id_use_rs1 = ($urandom_range(0, 3) != 0);
        id_use_rs2 = ($urandom_range(0, 2) != 0);
        id_rd      = RA_W'($urandom_range(0, 7));
        id_rf_le   = ($urandom_range(0, 4) != 0);
        id_load    = ($urandom_range(0, 2) == 0);
      end
      ex_br_taken = (c < 3) ? 1'b1 :
                    (bubbles == 0 && hist[0].v && $urandom_range(0, 5) == 0);

      lu = hist[0].v && hist[0].ld && hist[0].le &&
           ((id_use_rs1 && id_rs1 != 0 && id_rs1 == hist[0].rd) ||
            (id_use_rs2 && id_rs2 != 0 && id_rs2 == hist[0].rd));

      if (!rst_n) begin
        e.ctrl = 5'b11000;
        e.fwd  = 4'b0000;
      end else begin
        e.fwd = {ref_fwd(id_use_rs1, id_rs1), ref_fwd(id_use_rs2, id_rs2)};
        if (mem_wait)         e.ctrl = 5'b00001;
        else if (bubbles > 0) e.ctrl = 5'b00011;
        else if (ex_br_taken) e.ctrl = 5'b11110;
        else if (lu)          e.ctrl = 5'b00011;
        else                  e.ctrl = 5'b11000;
      end
      exp_q.push_back(e);

      if (bubbles > 0) p_bub_next = bubbles - 1;
      else if (lu && !ex_br_taken) p_bub_next = LU - 1;
      else p_bub_next = 0;
      p_rst = rst_n;
      p_mw  = mem_wait;
      p_nop = e.ctrl[1];
      p_rd  = id_rd;
      p_le  = id_rf_le;
      p_ld  = id_load;
      // IF/ID holds its instruction while not loading.
      hold  = rst_n && !e.ctrl[3];
    end

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
